// File: rtl/jt49_noise_chk_if.sv
// jt49_noise_chk_if: bundles the per-cycle controls, the observed noise bit and the
// checker status outputs of jt49_noise_chk.
//   master: drives cen, clr, shift, noise; observes the status outputs.
//   slave : the checker itself.
// ERR_W / IVL_W must match the parameters of the checker this interface is bound to.
interface jt49_noise_chk_if #(
  parameter int unsigned ERR_W = 8,
  parameter int unsigned IVL_W = 10
);
  logic             cen;       // clock enable
  logic             clr;       // synchronous restart, qualified by cen
  logic             shift;     // new noise bit valid this cycle
  logic             noise;     // observed noise bit
  logic             locked;    // checker is locked to the sequence
  logic             err;       // sticky mismatch flag while locked
  logic [ERR_W-1:0] err_cnt;   // saturating mismatch count while locked
  logic [IVL_W-1:0] interval;  // cen cycles between the last two shifts
  logic             ivl_vld;   // interval holds a full measurement

  modport master (
    output cen, clr, shift, noise,
    input  locked, err, err_cnt, interval, ivl_vld
  );

  modport slave (
    input  cen, clr, shift, noise,
    output locked, err, err_cnt, interval, ivl_vld
  );
endinterface

// File: rtl/jt49_noise_chk.sv
// jt49_noise_chk: receive-side checker for the 17-bit noise LFSR bitstream.
// Rebuilds the sequence s[n+17] = s[n] ^ s[n+3] ^ (history == 0) from the observed
// noise bit, locks onto it, then flywheels its own prediction and counts mismatches.
// It also measures the spacing between shift events in cen cycles.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous reset, active low
//   bus   - slave modport of jt49_noise_chk_if (cen, clr, shift, noise in;
//           locked, err, err_cnt, interval, ivl_vld out). All outputs registered.
module jt49_noise_chk #(
  parameter int unsigned CONFIRM  = 17,  // correct predictions to go CONFIRM->LOCKED
  parameter int unsigned MISS_MAX = 2,   // consecutive misses in LOCKED to fall back
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned IVL_W    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  jt49_noise_chk_if.slave bus
);

  localparam int unsigned ConfW = $clog2(CONFIRM + 1);
  localparam int unsigned MissW = $clog2(MISS_MAX + 1);
  localparam logic [ConfW-1:0] ConfLast = ConfW'(CONFIRM - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(MISS_MAX - 1);
  localparam logic [4:0]       FillLast = 5'd16;

  typedef enum logic [1:0] {
    StSearch,
    StConfirm,
    StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [16:0]      hist_q, hist_d;      // hist[0] is the oldest bit
  logic [4:0]       fill_q, fill_d;
  logic [ConfW-1:0] conf_q, conf_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [IVL_W-1:0] ivl_cnt_q, ivl_cnt_d;
  logic [IVL_W-1:0] interval_q, interval_d;
  logic             ivl_vld_q, ivl_vld_d;
  logic             seen_q, seen_d;      // at least one event since restart

  logic restart;
  logic evt;
  logic pred;
  logic miss_now;

  // clr beats a coincident shift, so the sample is dropped.
  assign restart  = bus.cen & bus.clr;
  assign evt      = bus.cen & bus.shift & ~bus.clr;
  // The all-zero term lets the sequence escape the otherwise stuck zero state.
  assign pred     = hist_q[0] ^ hist_q[3] ^ (hist_q == 17'd0);
  assign miss_now = bus.noise ^ pred;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    conf_d     = conf_q;
    miss_d     = miss_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    ivl_cnt_d  = ivl_cnt_q;
    interval_d = interval_q;
    ivl_vld_d  = ivl_vld_q;
    seen_d     = seen_q;

    if (restart) begin
      state_d    = StSearch;
      hist_d     = '0;
      fill_d     = '0;
      conf_d     = '0;
      miss_d     = '0;
      err_d      = 1'b0;
      err_cnt_d  = '0;
      ivl_cnt_d  = '0;
      interval_d = '0;
      ivl_vld_d  = 1'b0;
      seen_d     = 1'b0;
    end else if (bus.cen) begin
      // Interval measurement: the first event only restarts the count.
      if (evt) begin
        ivl_cnt_d = '0;
        seen_d    = 1'b1;
        if (seen_q) begin
          interval_d = (ivl_cnt_q == '1) ? '1 : ivl_cnt_q + IVL_W'(1);
          ivl_vld_d  = 1'b1;
        end
      end else if (ivl_cnt_q != '1) begin
        ivl_cnt_d = ivl_cnt_q + IVL_W'(1);
      end

      if (evt) begin
        unique case (state_q)
          StSearch: begin
            hist_d = {bus.noise, hist_q[16:1]};
            fill_d = fill_q + 5'd1;
            if (fill_q == FillLast) begin
              state_d = StConfirm;
              conf_d  = '0;
            end
          end
          StConfirm: begin
            hist_d = {bus.noise, hist_q[16:1]};
            if (!miss_now) begin
              conf_d = conf_q + ConfW'(1);
              if (conf_q == ConfLast) begin
                state_d = StLocked;
                miss_d  = '0;
              end
            end else begin
              conf_d = '0;
            end
          end
          StLocked: begin
            // Flywheel: the history follows the prediction, not the received bit,
            // so a corrupted sample does not poison later predictions.
            hist_d = {pred, hist_q[16:1]};
            if (miss_now) begin
              err_d = 1'b1;
              if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
              end
              if (miss_q == MissLast) begin
                state_d = StConfirm;
                conf_d  = '0;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + MissW'(1);
              end
            end else begin
              miss_d = '0;
            end
          end
          default: state_d = StSearch;
        endcase
      end
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSearch;
      hist_q     <= '0;
      fill_q     <= '0;
      conf_q     <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      ivl_cnt_q  <= '0;
      interval_q <= '0;
      ivl_vld_q  <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      conf_q     <= conf_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      ivl_cnt_q  <= ivl_cnt_d;
      interval_q <= interval_d;
      ivl_vld_q  <= ivl_vld_d;
      seen_q     <= seen_d;
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.interval = interval_q;
  assign bus.ivl_vld  = ivl_vld_q;

  // A non-zero error count always comes with the sticky flag.
  a_cnt_implies_err: assert property (@(posedge clk) disable iff (!rst_n)
    (err_cnt_q != '0) |-> err_q);
  // The locked output mirrors the state register.
  a_locked_state: assert property (@(posedge clk) disable iff (!rst_n)
    locked_q == (state_q == StLocked));

endmodule
